// File: rtl/mem_stage_if.sv
// Bundles the upstream operand side, data-memory bus and writeback side of mem_stage.
// No storage of its own; latency belongs to the stage that uses it.
// Backpressure is carried by stall_out (to upstream) and mem_req/mem_ack (to memory).
`ifndef MEM_STAGE_TRAP_CODES
`define MEM_STAGE_TRAP_CODES
`define TRAP_STALL    8'h01
`define TRAP_OVERFLOW 8'h02
`endif

interface mem_stage_if;
   // upstream (ALU stage) side
   logic [7:0]  exception_in;
   logic [2:0]  mem_op;
   logic [31:0] addr_in;
   logic [31:0] store_val;
   logic [4:0]  dst_reg_in;
   // data-memory bus
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   // writeback side
   logic [31:0] wb_val;
   logic [4:0]  wb_reg;
   logic        wb_en;
   logic [7:0]  exception;
   logic        stall_out;

   // the memory stage itself
   modport slave (
      input  exception_in, mem_op, addr_in, store_val, dst_reg_in, mem_ack, mem_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be, wb_val, wb_reg, wb_en,
             exception, stall_out
   );

   // whatever drives the stage: upstream pipeline plus memory model
   modport master (
      output exception_in, mem_op, addr_in, store_val, dst_reg_in, mem_ack, mem_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be, wb_val, wb_reg, wb_en,
             exception, stall_out
   );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory-access stage: forwards ALU results, performs lw/lb/lbu/sw/sb over a req/ack bus.
// Latency: 1 cycle for forwards/traps, 2+ cycles (request edge + ack edge) for memory ops.
// Holds stall_out high while a request is outstanding; bounded wait ends in a bus-error trap.
`ifndef MEM_STAGE_TRAP_CODES
`define MEM_STAGE_TRAP_CODES
`define TRAP_STALL    8'h01
`define TRAP_OVERFLOW 8'h02
`endif

module mem_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [7:0]  TRAP_ALIGN     = 8'h04,
   parameter logic [7:0]  TRAP_BUS       = 8'h05
) (
   input logic        clk,
   input logic        rst,
   mem_stage_if.slave bus
);

   typedef enum logic {IDLE, WAIT} state_t;

   // context of the access in flight, captured at the request edge
   typedef struct packed {
      logic [2:0] op;
      logic [1:0] off;
      logic [4:0] dst;
   } ctx_t;

   localparam logic [2:0] OP_NONE = 3'd0;
   localparam logic [2:0] OP_LW   = 3'd1;
   localparam logic [2:0] OP_LB   = 3'd2;
   localparam logic [2:0] OP_LBU  = 3'd3;
   localparam logic [2:0] OP_SW   = 3'd4;
   localparam logic [2:0] OP_SB   = 3'd5;
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   ctx_t        ctx_q, ctx_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] wb_val_q, wb_val_d;
   logic [4:0]  wb_reg_q, wb_reg_d;
   logic        wb_en_q, wb_en_d;
   logic [7:0]  exc_q, exc_d;
   logic        stall_q, stall_d;

   logic [7:0]  rbyte;
   logic [31:0] load_val;
   logic        op_is_none;
   logic        op_is_word;
   logic        op_is_load;

   // decode helpers; opcodes 6/7 behave exactly like "none"
   always_comb begin
      op_is_none = (bus.mem_op == OP_NONE) || (bus.mem_op > OP_SB);
      op_is_word = (bus.mem_op == OP_LW) || (bus.mem_op == OP_SW);
      op_is_load = (ctx_q.op == OP_LW) || (ctx_q.op == OP_LB) || (ctx_q.op == OP_LBU);
   end

   // pick the addressed byte lane of the read data and extend it for lb/lbu
   always_comb begin
      rbyte = 8'h00;
      case (ctx_q.off)
         2'd0: rbyte = bus.mem_rdata[7:0];
         2'd1: rbyte = bus.mem_rdata[15:8];
         2'd2: rbyte = bus.mem_rdata[23:16];
         2'd3: rbyte = bus.mem_rdata[31:24];
         default: rbyte = 8'h00;
      endcase
      load_val = bus.mem_rdata;
      if (ctx_q.op == OP_LB) begin
         load_val = {{24{rbyte[7]}}, rbyte};
      end else if (ctx_q.op == OP_LBU) begin
         load_val = {24'h0, rbyte};
      end
   end

   // next-state and next-output computation; every register holds unless overridden
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ctx_d       = ctx_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      wb_val_d    = wb_val_q;
      wb_reg_d    = wb_reg_q;
      wb_en_d     = wb_en_q;
      exc_d       = exc_q;
      stall_d     = stall_q;

      case (state_q)
         IDLE: begin
            wb_en_d   = 1'b0;
            exc_d     = 8'h00;
            stall_d   = 1'b0;
            mem_req_d = 1'b0;
            if (bus.exception_in != 8'h00) begin
               // upstream already trapped: pass the code along, no access
               exc_d = bus.exception_in;
            end else if (op_is_none) begin
               wb_val_d = bus.addr_in;
               wb_reg_d = bus.dst_reg_in;
               wb_en_d  = (bus.dst_reg_in != 5'd0);
            end else if (op_is_word && (bus.addr_in[1:0] != 2'b00)) begin
               exc_d = TRAP_ALIGN;
            end else begin
               mem_req_d  = 1'b1;
               mem_addr_d = {bus.addr_in[31:2], 2'b00};
               mem_we_d   = (bus.mem_op == OP_SW) || (bus.mem_op == OP_SB);
               mem_be_d   = 4'hF;
               if (bus.mem_op == OP_SW) begin
                  mem_wdata_d = bus.store_val;
               end else if (bus.mem_op == OP_SB) begin
                  mem_be_d    = 4'b0001 << bus.addr_in[1:0];
                  mem_wdata_d = {4{bus.store_val[7:0]}};
               end
               stall_d   = 1'b1;
               exc_d     = `TRAP_STALL;
               cnt_d     = 8'd0;
               ctx_d.op  = bus.mem_op;
               ctx_d.off = bus.addr_in[1:0];
               ctx_d.dst = bus.dst_reg_in;
               state_d   = WAIT;
            end
         end
         WAIT: begin
            if (bus.mem_ack) begin
               // ack takes priority over a timeout on the same edge
               mem_req_d = 1'b0;
               stall_d   = 1'b0;
               exc_d     = 8'h00;
               state_d   = IDLE;
               wb_en_d   = 1'b0;
               if (op_is_load) begin
                  wb_en_d  = (ctx_q.dst != 5'd0);
                  wb_reg_d = ctx_q.dst;
                  wb_val_d = load_val;
               end
            end else if (cnt_q == CNT_LAST) begin
               mem_req_d = 1'b0;
               stall_d   = 1'b0;
               exc_d     = TRAP_BUS;
               state_d   = IDLE;
            end else begin
               cnt_d   = cnt_q + 8'd1;
               stall_d = 1'b1;
               exc_d   = `TRAP_STALL;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state and registered outputs; synchronous reset also aborts an access in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 8'd0;
         ctx_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         mem_be_q    <= 4'h0;
         wb_val_q    <= 32'h0;
         wb_reg_q    <= 5'd0;
         wb_en_q     <= 1'b0;
         exc_q       <= `TRAP_STALL;
         stall_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ctx_q       <= ctx_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         wb_val_q    <= wb_val_d;
         wb_reg_q    <= wb_reg_d;
         wb_en_q     <= wb_en_d;
         exc_q       <= exc_d;
         stall_q     <= stall_d;
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_be    = mem_be_q;
   assign bus.wb_val    = wb_val_q;
   assign bus.wb_reg    = wb_reg_q;
   assign bus.wb_en     = wb_en_q;
   assign bus.exception = exc_q;
   assign bus.stall_out = stall_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a writeback scoreboard.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
// Memory acks are driven by the bench to model zero-wait, wait-state and dead memories.
`ifndef MEM_STAGE_TRAP_CODES
`define MEM_STAGE_TRAP_CODES
`define TRAP_STALL    8'h01
`define TRAP_OVERFLOW 8'h02
`endif

module tb_mem_stage;

   localparam logic [7:0] T_ALIGN = 8'h04;
   localparam logic [7:0] T_BUS   = 8'h05;

   typedef struct {
      logic [31:0] val;
      logic [4:0]  rg;
      logic        en;
      logic [7:0]  exc;
   } wb_exp_t;

   logic clk;
   logic rst;
   int   tests;
   int   fails;
   wb_exp_t sb[$];

   mem_stage_if ifc ();

   mem_stage #(
      .TIMEOUT_CYCLES(255),
      .TRAP_ALIGN    (T_ALIGN),
      .TRAP_BUS      (T_BUS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(ifc.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_wb(input logic [31:0] val, input logic [4:0] rg, input logic en,
                          input logic [7:0] exc);
      wb_exp_t e;
      e.val = val;
      e.rg  = rg;
      e.en  = en;
      e.exc = exc;
      sb.push_back(e);
   endtask

   // pop the oldest expected writeback and compare against the stage outputs
   task automatic check_wb(input string tag);
      wb_exp_t e;
      if (sb.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL %s: observed empty scoreboard expected an entry", tag);
      end else begin
         e = sb.pop_front();
         check({tag, ".wb_en"}, 32'(ifc.wb_en), 32'(e.en));
         check({tag, ".exc"}, 32'(ifc.exception), 32'(e.exc));
         if (e.en) begin
            check({tag, ".wb_val"}, ifc.wb_val, e.val);
            check({tag, ".wb_reg"}, 32'(ifc.wb_reg), 32'(e.rg));
         end
      end
   endtask

   task automatic idle_inputs();
      ifc.exception_in = 8'h00;
      ifc.mem_op       = 3'd0;
      ifc.addr_in      = 32'h0;
      ifc.store_val    = 32'h0;
      ifc.dst_reg_in   = 5'd0;
   endtask

   // one complete memory access: request, optional wait states, ack, writeback check
   task automatic do_access(input string tag, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] sv, input logic [4:0] dst, input int waits,
                            input logic [31:0] rdata, input logic [31:0] exp_val,
                            input logic exp_en, input logic exp_we, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata);
      ifc.exception_in = 8'h00;
      ifc.mem_op       = op;
      ifc.addr_in      = addr;
      ifc.store_val    = sv;
      ifc.dst_reg_in   = dst;
      push_wb(exp_val, dst, exp_en, 8'h00);
      step();
      check({tag, ".req"}, 32'(ifc.mem_req), 32'd1);
      check({tag, ".addr"}, ifc.mem_addr, {addr[31:2], 2'b00});
      check({tag, ".we"}, 32'(ifc.mem_we), 32'(exp_we));
      check({tag, ".be"}, 32'(ifc.mem_be), 32'(exp_be));
      if (exp_we) check({tag, ".wdata"}, ifc.mem_wdata, exp_wdata);
      check({tag, ".stall"}, 32'(ifc.stall_out), 32'd1);
      check({tag, ".exc_stall"}, 32'(ifc.exception), 32'(`TRAP_STALL));
      check({tag, ".wb_en_req"}, 32'(ifc.wb_en), 32'd0);
      if (waits > 0) begin
         repeat (waits) step();
         check({tag, ".req_held"}, 32'(ifc.mem_req), 32'd1);
         check({tag, ".stall_held"}, 32'(ifc.stall_out), 32'd1);
      end
      ifc.mem_ack   = 1'b1;
      ifc.mem_rdata = rdata;
      step();
      ifc.mem_ack = 1'b0;
      idle_inputs();
      check_wb(tag);
      check({tag, ".req_drop"}, 32'(ifc.mem_req), 32'd0);
      check({tag, ".stall_drop"}, 32'(ifc.stall_out), 32'd0);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst   = 1'b1;
      idle_inputs();
      ifc.mem_ack   = 1'b0;
      ifc.mem_rdata = 32'h0;
      step();
      step();

      // reset state
      check("rst.exc", 32'(ifc.exception), 32'(`TRAP_STALL));
      check("rst.req", 32'(ifc.mem_req), 32'd0);
      check("rst.wb_en", 32'(ifc.wb_en), 32'd0);
      check("rst.stall", 32'(ifc.stall_out), 32'd0);
      check("rst.wb_val", ifc.wb_val, 32'h0);
      check("rst.addr", ifc.mem_addr, 32'h0);
      rst = 1'b0;

      // ack while idle is ignored; first idle edge clears the reset trap code
      ifc.mem_ack   = 1'b1;
      ifc.mem_rdata = 32'hCAFEF00D;
      push_wb(32'h0, 5'd0, 1'b0, 8'h00);
      step();
      ifc.mem_ack = 1'b0;
      check_wb("idle_ack");
      check("idle_ack.req", 32'(ifc.mem_req), 32'd0);

      // forward path
      ifc.mem_op     = 3'd0;
      ifc.addr_in    = 32'h1234;
      ifc.dst_reg_in = 5'd3;
      push_wb(32'h1234, 5'd3, 1'b1, 8'h00);
      step();
      check_wb("fwd");
      check("fwd.stall", 32'(ifc.stall_out), 32'd0);

      // forward to $0 never enables writeback; op 7 behaves as none
      ifc.mem_op     = 3'd7;
      ifc.addr_in    = 32'h5555;
      ifc.dst_reg_in = 5'd0;
      push_wb(32'h5555, 5'd0, 1'b0, 8'h00);
      step();
      check_wb("fwd_r0");
      check("fwd_r0.req", 32'(ifc.mem_req), 32'd0);
      idle_inputs();

      do_access("lw0", 3'd1, 32'h100, 32'h0, 5'd5, 0, 32'hDEADBEEF, 32'hDEADBEEF,
                1'b1, 1'b0, 4'hF, 32'h0);
      do_access("lb", 3'd2, 32'h103, 32'h0, 5'd6, 0, 32'h80FF0000, 32'hFFFFFF80,
                1'b1, 1'b0, 4'hF, 32'h0);
      do_access("lbu", 3'd3, 32'h103, 32'h0, 5'd7, 0, 32'h80FF0000, 32'h00000080,
                1'b1, 1'b0, 4'hF, 32'h0);
      do_access("lb1", 3'd2, 32'h101, 32'h0, 5'd8, 0, 32'h12347F56, 32'h0000007F,
                1'b1, 1'b0, 4'hF, 32'h0);
      do_access("sb", 3'd5, 32'h202, 32'hAB, 5'd9, 0, 32'h0, 32'h0,
                1'b0, 1'b1, 4'b0100, 32'hABABABAB);
      do_access("sw_wait", 3'd4, 32'h204, 32'h13579BDF, 5'd0, 3, 32'h0, 32'h0,
                1'b0, 1'b1, 4'hF, 32'h13579BDF);
      do_access("lw_wait", 3'd1, 32'h208, 32'h0, 5'd10, 4, 32'h0BADF00D, 32'h0BADF00D,
                1'b1, 1'b0, 4'hF, 32'h0);
      do_access("lw_r0", 3'd1, 32'h20C, 32'h0, 5'd0, 0, 32'h11111111, 32'h0,
                1'b0, 1'b0, 4'hF, 32'h0);

      // misaligned word store traps without a request
      ifc.mem_op     = 3'd4;
      ifc.addr_in    = 32'h201;
      ifc.store_val  = 32'h77;
      ifc.dst_reg_in = 5'd4;
      push_wb(32'h0, 5'd4, 1'b0, T_ALIGN);
      step();
      check_wb("misalign");
      check("misalign.req", 32'(ifc.mem_req), 32'd0);
      check("misalign.stall", 32'(ifc.stall_out), 32'd0);

      // upstream exception passes through and suppresses the load
      ifc.exception_in = `TRAP_OVERFLOW;
      ifc.mem_op       = 3'd1;
      ifc.addr_in      = 32'h300;
      ifc.dst_reg_in   = 5'd4;
      push_wb(32'h0, 5'd4, 1'b0, `TRAP_OVERFLOW);
      step();
      check_wb("exc_in");
      check("exc_in.req", 32'(ifc.mem_req), 32'd0);
      idle_inputs();
      step();

      // dead memory: 255 wait edges then bus-error trap
      ifc.mem_op     = 3'd1;
      ifc.addr_in    = 32'h400;
      ifc.dst_reg_in = 5'd11;
      step();
      idle_inputs();
      check("tmo.req", 32'(ifc.mem_req), 32'd1);
      repeat (254) step();
      check("tmo.req_254", 32'(ifc.mem_req), 32'd1);
      check("tmo.exc_254", 32'(ifc.exception), 32'(`TRAP_STALL));
      push_wb(32'h0, 5'd11, 1'b0, T_BUS);
      step();
      check_wb("tmo");
      check("tmo.req_drop", 32'(ifc.mem_req), 32'd0);
      check("tmo.stall_drop", 32'(ifc.stall_out), 32'd0);

      // ack on the very edge that would time out: ack wins
      ifc.mem_op     = 3'd1;
      ifc.addr_in    = 32'h404;
      ifc.dst_reg_in = 5'd12;
      step();
      idle_inputs();
      repeat (254) step();
      ifc.mem_ack   = 1'b1;
      ifc.mem_rdata = 32'h11223344;
      push_wb(32'h11223344, 5'd12, 1'b1, 8'h00);
      step();
      ifc.mem_ack = 1'b0;
      check_wb("ack_at_tmo");
      check("ack_at_tmo.req", 32'(ifc.mem_req), 32'd0);

      // reset during WAIT aborts the access; a late ack is ignored
      ifc.mem_op     = 3'd1;
      ifc.addr_in    = 32'h500;
      ifc.dst_reg_in = 5'd13;
      step();
      idle_inputs();
      check("rst_wait.req", 32'(ifc.mem_req), 32'd1);
      step();
      rst = 1'b1;
      step();
      check("rst_wait.req_drop", 32'(ifc.mem_req), 32'd0);
      check("rst_wait.exc", 32'(ifc.exception), 32'(`TRAP_STALL));
      check("rst_wait.stall", 32'(ifc.stall_out), 32'd0);
      rst = 1'b0;
      ifc.mem_ack   = 1'b1;
      ifc.mem_rdata = 32'h99999999;
      push_wb(32'h0, 5'd13, 1'b0, 8'h00);
      step();
      ifc.mem_ack = 1'b0;
      check_wb("late_ack");
      check("late_ack.req", 32'(ifc.mem_req), 32'd0);
      step();
      check("late_ack.wb_en2", 32'(ifc.wb_en), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
